instr_encoder: RTL



---
 rtl/instr_encoder_pkg.sv | 72 +++++++
 rtl/instr_encoder_encode_word.sv | 111 +++++++++++
 rtl/instr_encoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_encoder_pkg : op codes, RV32I opcode/func fields, FSM states, helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package instr_encoder_pkg;

  localparam logic [5:0] ENC_LUI   = 6'd0;
  localparam logic [5:0] ENC_AUIPC = 6'd1;
  localparam logic [5:0] ENC_JAL   = 6'd2;
  localparam logic [5:0] ENC_JALR  = 6'd3;
  localparam logic [5:0] ENC_BEQ   = 6'd4;
  localparam logic [5:0] ENC_BNE   = 6'd5;
  localparam logic [5:0] ENC_BLT   = 6'd6;
  localparam logic [5:0] ENC_BGE   = 6'd7;
  localparam logic [5:0] ENC_BLTU  = 6'd8;
  localparam logic [5:0] ENC_BGEU  = 6'd9;
  localparam logic [5:0] ENC_LB    = 6'd10;
  localparam logic [5:0] ENC_LH    = 6'd11;
  localparam logic [5:0] ENC_LW    = 6'd12;
  localparam logic [5:0] ENC_LBU   = 6'd13;
  localparam logic [5:0] ENC_LHU   = 6'd14;
  localparam logic [5:0] ENC_SB    = 6'd15;
  localparam logic [5:0] ENC_SH    = 6'd16;
  localparam logic [5:0] ENC_SW    = 6'd17;
  localparam logic [5:0] ENC_ADDI  = 6'd18;
  localparam logic [5:0] ENC_SLTI  = 6'd19;
  localparam logic [5:0] ENC_SLTIU = 6'd20;
  localparam logic [5:0] ENC_XORI  = 6'd21;
  localparam logic [5:0] ENC_ORI   = 6'd22;
  localparam logic [5:0] ENC_ANDI  = 6'd23;
  localparam logic [5:0] ENC_SLLI  = 6'd24;
  localparam logic [5:0] ENC_SRLI  = 6'd25;
  localparam logic [5:0] ENC_SRAI  = 6'd26;
  localparam logic [5:0] ENC_ADD   = 6'd27;
  localparam logic [5:0] ENC_SUB   = 6'd28;
  localparam logic [5:0] ENC_SLL   = 6'd29;
  localparam logic [5:0] ENC_SLT   = 6'd30;
  localparam logic [5:0] ENC_SLTU  = 6'd31;
  localparam logic [5:0] ENC_XOR   = 6'd32;
  localparam logic [5:0] ENC_SRL   = 6'd33;
  localparam logic [5:0] ENC_SRA   = 6'd34;
  localparam logic [5:0] ENC_OR    = 6'd35;
  localparam logic [5:0] ENC_AND   = 6'd36;
  localparam logic [5:0] ENC_LI    = 6'd37;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_LI_LO = 1'b1;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  function automatic logic fits_simm12(input logic [31:0] imm);
    return (&imm[31:11]) || (~|imm[31:11]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_encode_word.sv
`default_nettype none
// ----------------------------------------------------------------------------
// encode_word : combinational {op, rd, rs1, rs2, imm} -> {RV32I word, legal}
// Rev 1.0
// ----------------------------------------------------------------------------
module encode_word
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  fmt_e       fmt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    fmt = FMT_BAD;
    opc = OPC_OP;
    f3  = 3'd0;
    f7  = F7_BASE;
    case (op_i)
      ENC_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;                 end
      ENC_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC;               end
      ENC_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;                 end
      ENC_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;               end
      ENC_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd0;  end
      ENC_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd1;  end
      ENC_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd4;  end
      ENC_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd5;  end
      ENC_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd6;  end
      ENC_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd7;  end
      ENC_LB:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd0;  end
      ENC_LH:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd1;  end
      ENC_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd2;  end
      ENC_LBU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd4;  end
      ENC_LHU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd5;  end
      ENC_SB:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd0;  end
      ENC_SH:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd1;  end
      ENC_SW:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd2;  end
      ENC_ADDI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = 3'd0;  end
      ENC_SLTI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = 3'd2;  end
      ENC_SLTIU: begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = 3'd3;  end
      ENC_XORI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = 3'd4;  end
      ENC_ORI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = 3'd6;  end
      ENC_ANDI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = 3'd7;  end
      ENC_SLLI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = 3'd1;  end
      ENC_SRLI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = 3'd5;  end
      ENC_SRAI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = 3'd5; f7 = F7_ALT; end
      ENC_ADD:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd0;  end
      ENC_SUB:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd0; f7 = F7_ALT; end
      ENC_SLL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd1;  end
      ENC_SLT:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd2;  end
      ENC_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd3;  end
      ENC_XOR:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd4;  end
      ENC_SRL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd5;  end
      ENC_SRA:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd5; f7 = F7_ALT; end
      ENC_OR:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd6;  end
      ENC_AND:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd7;  end
      default:   fmt = FMT_BAD;
    endcase
  end

  // LI and codes 38..63 fall through to FMT_BAD and are reported illegal
  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    case (fmt)
      FMT_R: begin
        word_o  = {f7, rs2_i, rs1_i, f3, rd_i, opc};
        legal_o = 1'b1;
      end
      FMT_I: begin
        word_o  = {imm_i[11:0], rs1_i, f3, rd_i, opc};
        legal_o = fits_simm12(imm_i);
      end
      FMT_SH: begin
        word_o  = {f7, imm_i[4:0], rs1_i, f3, rd_i, opc};
        legal_o = ~|imm_i[31:5];
      end
      FMT_S: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], opc};
        legal_o = fits_simm12(imm_i);
      end
      FMT_B: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], opc};
        legal_o = !imm_i[0] && ((&imm_i[31:12]) || (~|imm_i[31:12]));
      end
      FMT_U: begin
        word_o  = {imm_i[31:12], rd_i, opc};
        legal_o = ~|imm_i[11:0];
      end
      FMT_J: begin
        word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opc};
        legal_o = !imm_i[0] && ((&imm_i[31:20]) || (~|imm_i[31:20]));
      end
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_encoder : request/instr handshakes, LI expansion FSM, output register
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [5:0]         req_op_i,
  input  logic [4:0]         req_rd_i,
  input  logic [4:0]         req_rs1_i,
  input  logic [4:0]         req_rs2_i,
  input  logic [31:0]        req_imm_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [31:0]        instr_o,
  output logic               err_o,
  output logic [COUNT_W-1:0] count_o
);

  logic [0:0]         state_q, state_d;
  logic [31:0]        pend_q, pend_d;
  logic [31:0]        instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic        drain, accept;
  logic        is_li, li_fits, li_two;
  logic [19:0] li_hi;
  logic [5:0]  a_op;
  logic [4:0]  a_rs1;
  logic [31:0] a_imm, a_word, b_word;
  logic        a_legal, b_legal;

  assign drain       = valid_q && instr_ready_i;
  assign req_ready_o = (state_q == S_IDLE) && (!valid_q || instr_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // LI: hi is rounded so that the sign-extended low 12 bits restore the value
  assign is_li   = (req_op_i == ENC_LI);
  assign li_fits = fits_simm12(req_imm_i);
  assign li_hi   = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
  assign a_op    = is_li ? (li_fits ? ENC_ADDI : ENC_LUI) : req_op_i;
  assign a_rs1   = is_li ? 5'd0 : req_rs1_i;
  assign a_imm   = (is_li && !li_fits) ? {li_hi, 12'd0} : req_imm_i;
  assign li_two  = is_li && !li_fits && (req_imm_i[11:0] != 12'd0) && b_legal;

  encode_word u_enc_first (
    .op_i    (a_op),
    .rd_i    (req_rd_i),
    .rs1_i   (a_rs1),
    .rs2_i   (req_rs2_i),
    .imm_i   (a_imm),
    .word_o  (a_word),
    .legal_o (a_legal)
  );

  encode_word u_enc_li_lo (
    .op_i    (ENC_ADDI),
    .rd_i    (req_rd_i),
    .rs1_i   (req_rd_i),
    .rs2_i   (5'd0),
    .imm_i   ({{20{req_imm_i[11]}}, req_imm_i[11:0]}),
    .word_o  (b_word),
    .legal_o (b_legal)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    count_d = count_q + COUNT_W'(drain);

    if (drain) valid_d = 1'b0;

    if (state_q == S_LI_LO && drain) begin
      instr_d = pend_q;
      valid_d = 1'b1;
      pend_d  = '0;
      state_d = S_IDLE;
    end

    if (accept) begin
      if (!a_legal) begin
        err_d = 1'b1;
      end else begin
        instr_d = a_word;
        valid_d = 1'b1;
        if (li_two) begin
          pend_d  = b_word;
          state_d = S_LI_LO;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign err_o         = err_q;
  assign count_o       = count_q;

endmodule
`default_nettype wire
